// File: rtl/product_bcd_converter_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package product_bcd_pkg;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of one packed BCD digit.
  localparam int DIGIT_W = 4;

  // Digits at or above this value get +3 before each shift.
  localparam int ADD3_THRESH = 5;

  // Width of the bit counter that sequences BIN_WIDTH shift steps.
  function automatic int count_width(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

endpackage

// File: rtl/product_bcd_converter_if.sv
// Request/result bundle between the product source and the BCD converter.
//
// Handshake: the master raises start with bin_in valid; the slave accepts
// it only while busy is low (IDLE). busy stays high for the whole
// conversion, and done pulses for one cycle when bcd_out/blank hold the new
// result. start seen while busy is high is dropped, not queued.
interface product_bcd_converter_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
);
  logic                   start;
  logic [BIN_WIDTH-1:0]   bin_in;
  logic                   busy;
  logic                   done;
  logic [4*DIGITS-1:0]    bcd_out;
  logic [DIGITS-1:0]      blank;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, blank
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, blank
  );
endinterface

// File: rtl/product_bcd_converter_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
  import product_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Pre-shift correction so the doubled digit carries correctly into the next.
  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(ADD3_THRESH)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: one input bit per clock, result plus
// a leading-zero blanking mask for the 7-segment driver.
module product_bcd_converter
  import product_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  product_bcd_converter_if.slave bus,
  output state_e                state_dbg
);

  localparam int CW = count_width(BIN_WIDTH);
  localparam int SW = DIGIT_W * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  state_e                state;
  logic [BIN_WIDTH-1:0]  bin_reg;
  logic [SW-1:0]         scratch;
  logic [SW-1:0]         scratch_adj;
  logic [SW-1:0]         scratch_next;
  logic [CW-1:0]         count;
  logic [DIGITS-1:0]     blank_next;
  logic [SW-1:0]         bcd_q;
  logic [DIGITS-1:0]     blank_q;
  logic                  done_q;

  // One add-3 corrector per digit of the scratch register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (scratch[DIGIT_W*g +: DIGIT_W]),
      .dout (scratch_adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  // Adjusted scratch shifted left with the next binary MSB entering bit 0.
  always_comb begin
    scratch_next = SW'({scratch_adj, bin_reg[BIN_WIDTH-1]});
  end

  // Leading-zero mask of the value about to be published; units never blank.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (scratch_next[DIGIT_W*i +: DIGIT_W] != '0) seen = 1'b1;
      blank_next[i] = ~seen;
    end
  end

  // Control FSM, shift datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bin_reg <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bin_reg <= bus.bin_in;
            scratch <= '0;
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_next;
          bin_reg <= bin_reg << 1;
          count   <= count + CW'(1);
          if (count == CW'(BIN_WIDTH - 1)) begin
            bcd_q   <= scratch_next;
            blank_q <= blank_next;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // busy is a pure decode of state so it drops the same edge DONE is left.
  always_comb begin
    bus.busy    = (state != IDLE);
    bus.done    = done_q;
    bus.bcd_out = bcd_q;
    bus.blank   = blank_q;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed corner cases plus
// random products compared against a decimal-arithmetic reference model.
module tb_product_bcd_converter;
  import product_bcd_pkg::*;

  localparam int BW = 16;
  localparam int DG = 5;

  logic   clk;
  logic   rst_n;
  state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] exp_q[$];

  product_bcd_converter_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();

  product_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal digits by division, mask by scanning from the top.
  function automatic logic [4*DG-1:0] ref_bcd(input int unsigned v);
    logic [4*DG-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [DG-1:0] ref_blank(input int unsigned v);
    logic [DG-1:0] m;
    int unsigned p;
    m = '0;
    p = 1;
    for (int i = 1; i < DG; i++) begin
      p = p * 10;
      m[i] = (v < p);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_bcd"}, 32'(bus.bcd_out), 32'h00000);
    check({tag, "_blank"}, 32'(bus.blank), 32'b11110);
  endtask

  // Scoreboard: compare the published result with the oldest request.
  task automatic pop_and_check(input string tag);
    logic [BW-1:0] v;
    check({tag, "_q"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      check({tag, "_bcd"}, 32'(bus.bcd_out), 32'(ref_bcd(v)));
      check({tag, "_blank"}, 32'(bus.blank), 32'(ref_blank(v)));
    end
  endtask

  // Driver: one conversion with a latency check and busy/done framing.
  task automatic run_conv(input logic [BW-1:0] v);
    int  lat;
    bit  got;
    @(negedge clk);
    bus.bin_in = v;
    bus.start  = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = BW'($urandom_range(0, 65535));
    check("busy_rise", 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'd16);
      check("busy_in_done", 32'(bus.busy), 32'd1);
      pop_and_check("conv");
    end else begin
      exp_q.delete();
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("busy_fall", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [7:0] a, b;

    bus.start  = 1'b0;
    bus.bin_in = '0;
    rst_n      = 1'b0;

    // Reset then idle
    repeat (3) @(negedge clk);
    check_reset_values("rst_low");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("rst_rel");
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (4) @(negedge clk);
    check_reset_values("idle_hold");

    // Directed values and extremes
    run_conv(16'd1234);
    run_conv(16'd65535);
    run_conv(16'd0);
    run_conv(16'd65025);
    run_conv(16'd10000);
    run_conv(16'd9);

    // Start during busy is dropped
    @(negedge clk);
    bus.bin_in = 16'd42;
    bus.start  = 1'b1;
    exp_q.push_back(16'd42);
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("ign_latency", 32'(c), 32'd16);
        pop_and_check("ign");
        bus.bin_in = 16'd999;
        bus.start  = 1'b1;
      end else if (c == 3) begin
        bus.bin_in = 16'd999;
        bus.start  = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    exp_q.delete();
    run_conv(16'd999);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bus.bin_in = 16'd500;
    bus.start  = 1'b1;
    exp_q.push_back(16'd500);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_conv(16'd7);

    // Continuous start: captures every 18 cycles, bin_in stepped after each
    @(negedge clk);
    bus.bin_in = 16'd1;
    bus.start  = 1'b1;
    exp_q.push_back(16'd1);
    ndone = 0;
    for (int c = 0; c <= 72; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        check("cont_phase", 32'(c % 18), 32'd16);
        pop_and_check("cont");
      end
      if (c == 0 || c == 18 || c == 36) begin
        bus.bin_in = BW'(c / 18 + 2);
        exp_q.push_back(BW'(c / 18 + 2));
      end else if (c == 54) begin
        bus.start = 1'b0;
      end
    end
    check("cont_done_count", 32'(ndone), 32'd4);
    check("cont_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Random values and random byte products
    for (int i = 0; i < 12; i++) run_conv(BW'($urandom_range(0, 65535)));
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_conv(BW'(a) * BW'(b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
Name: product_bcd_converter

Overview:
Sequential double-dabble converter that sits directly downstream of the byte multiplier's registered 16-bit Product.
It converts an unsigned binary value to packed BCD digits, one bit per clock, behind a start/busy/done handshake.
It also produces a leading-zero blanking mask, so the 7-segment display driver can show the product in decimal.

Parameters:
- BIN_WIDTH, 16, width of the unsigned binary input.
- DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_WIDTH - 1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  BIN_WIDTH  unsigned binary value (multiplier Product).
- busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
- done  output  1  one-cycle pulse: bcd_out/blank are updated and valid.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- blank  output  DIGITS  1 = digit is a leading zero to be blanked; bit 0 is always 0.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, busy=0, done=0.
  - bcd_out=0, blank = all ones except bit 0 (5'b11110 at default).
  - internal shift/scratch/counter registers = 0.
- States: IDLE, SHIFT, DONE; encoding lives in the package.
- IDLE:
  - If start=1 at a rising edge: bin_reg<=bin_in, scratch<=0, count<=0, state<=SHIFT.
  - If start=0: remain in IDLE. bcd_out/blank hold the last result.
- SHIFT, each edge:
  - Every scratch digit >=5 gets +3 (combinational adjust).
  - Then {scratch, bin_reg} shifts left by 1; the MSB of bin_reg enters scratch bit 0.
  - count increments.
  - On the edge where count == BIN_WIDTH-1:
    - bcd_out <= final adjusted-and-shifted scratch.
    - blank <= computed mask.
    - state <= DONE.
- DONE: done=1 for exactly this one cycle, then state<=IDLE. busy is still 1 in DONE.
- Latency:
  - Start captured at edge k, SHIFT edges k+1..k+BIN_WIDTH.
  - done is high in the cycle following edge k+BIN_WIDTH, i.e. 16 cycles after capture at default.
  - Back-to-back throughput is one conversion per BIN_WIDTH+2 cycles.
- busy: 1 from the edge after start capture until the edge that leaves DONE; combinational decode of state.
- start while busy=1 (SHIFT or DONE) is ignored; it is not queued.
- start held high continuously gives a new conversion every BIN_WIDTH+2 cycles; bin_in is re-sampled each time.
- bin_in may change freely after the capture edge; the conversion uses the latched value.
- Blank mask rule:
  - Scan from the MSB digit downward. blank[i]=1 while digit i == 0 and all higher digits are 0.
  - blank[0] is forced to 0, so a value of 0 displays "0".
- Reset asserted mid-conversion aborts immediately to the reset values; no done pulse follows.
- Arithmetic:
  - Scratch is 4*DIGITS bits. The adjust never overflows a digit, because a digit is at most 9 after each shift.
  - The maximum input 2^BIN_WIDTH-1 must convert exactly.

Decomposition:
- Package product_bcd_pkg holds:
  - state typedef (enum IDLE/SHIFT/DONE);
  - localparams for BCD digit width (4) and the add-3 threshold (5);
  - a function computing the count width, $clog2(BIN_WIDTH).
- Sub-module bcd_digit_adjust: combinational, 4-bit in/out, adds 3 when the input is >=5. Instantiated DIGITS times via generate.
- The top module holds the FSM, counter, shift datapath and blank logic.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release -> busy=0, done=0, bcd_out=20'h00000, blank=5'b11110; outputs stable with start=0.
- Single conversion: bin_in=16'd1234, pulse start -> busy rises next cycle; done pulses exactly 16 cycles after capture; bcd_out=20'h01234, blank=5'b10000.
- Extremes:
  - bin_in=16'd65535 -> bcd_out=20'h65535, blank=5'b00000.
  - bin_in=0 -> bcd_out=20'h00000, blank=5'b11110.
  - bin_in=16'd65025 (255*255) -> 20'h65025.
- Start during busy: start conversion of 16'd42, re-pulse start with bin_in=16'd999 at cycles 3 and DONE cycle -> only one done; bcd_out=20'h00042; next IDLE start converts 999 -> 20'h00999, blank=5'b11000.
- Reset mid-conversion: start 16'd500, assert reset at cycle 8 -> outputs return to reset values immediately; no done; a subsequent start of 16'd7 yields 20'h00007, blank=5'b11110.
- Continuous start: start held high, bin_in stepping 1,2,3 -> done every 18 cycles; bcd_out sequence reflects the value sampled at each IDLE capture edge.
